// File: rtl/decode_exec_mem.sv
// Single-cycle decode, registered ALU/branch execute stage and a 256x8 data memory.
// Decode is purely combinational; execute and memory update on strobes.
module decode_exec_mem #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        instruction,
    input  logic [7:0]        pc,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              exec_en,
    input  logic              mem_en,
    input  logic [7:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        reg_addr_0,
    output logic [1:0]        reg_addr_1,
    output logic [1:0]        reg_addr_w,
    output logic              reg_w_en,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic              sel_w_source,
    output logic              jump,
    output logic              halt,
    output logic [DATA_W-1:0] alu_result,
    output logic              overflow,
    output logic              branch,
    output logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
        OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_SHL = 4'h7,
        OP_SHR = 4'h8, OP_ADDI = 4'h9, OP_LW = 4'hA, OP_SW = 4'hB,
        OP_BEQ = 4'hC, OP_BNE = 4'hD, OP_J = 4'hE, OP_JAL = 4'hF
    } opcode_t;

    opcode_t opcode;
    assign opcode = opcode_t'(instruction[7:4]);

    // Decode flags
    always_comb begin
        reg_addr_0   = instruction[3:2];
        reg_addr_1   = instruction[1:0];
        reg_addr_w   = (opcode == OP_JAL) ? 2'd3 : instruction[3:2];
        reg_w_en     = ((opcode >= OP_ADD) && (opcode <= OP_LW)) || (opcode == OP_JAL);
        mem_r_en     = (opcode == OP_LW);
        sel_w_source = (opcode == OP_LW);
        mem_w_en     = (opcode == OP_SW);
        jump         = instruction[7:6] == 2'b11;
        halt         = instruction == 8'h00;
    end

    // Next-state values for the execute registers
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_next;
    logic              ovf_next;
    logic              branch_next;

    assign imm = {{(DATA_W-2){1'b0}}, instruction[1:0]};

    always_comb begin
        alu_next    = '0;
        ovf_next    = 1'b0;
        branch_next = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_next = in0 + in1;
                ovf_next = (in0[DATA_W-1] == in1[DATA_W-1]) && (alu_next[DATA_W-1] != in0[DATA_W-1]);
            end
            OP_SUB: begin
                alu_next = in0 - in1;
                ovf_next = (in0[DATA_W-1] != in1[DATA_W-1]) && (alu_next[DATA_W-1] != in0[DATA_W-1]);
            end
            OP_ADDI: begin
                alu_next = in0 + imm;
                ovf_next = !in0[DATA_W-1] && alu_next[DATA_W-1];
            end
            OP_AND: alu_next = in0 & in1;
            OP_OR:  alu_next = in0 | in1;
            OP_XOR: alu_next = in0 ^ in1;
            OP_NOT: alu_next = ~in1;
            OP_SHL: alu_next = in1 << 1;
            OP_SHR: alu_next = in1 >> 1;
            OP_BEQ: begin
                alu_next    = in0 - in1;
                branch_next = (in0 == in1);
            end
            OP_BNE: begin
                alu_next    = in0 - in1;
                branch_next = (in0 != in1);
            end
            OP_J:   branch_next = 1'b1;
            OP_JAL: begin
                alu_next    = DATA_W'(pc + 8'd1);
                branch_next = 1'b1;
            end
            default: alu_next = '0;
        endcase
    end

    // Strobes are single-cycle enables with no back-pressure: an operation
    // happens on every clk edge where its strobe is high and reset is low.
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result <= '0;
            overflow   <= 1'b0;
            branch     <= 1'b0;
            mem_rdata  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (exec_en) begin
                alu_result <= alu_next;
                overflow   <= ovf_next;
                branch     <= branch_next;
            end
            if (mem_en && mem_w_en) mem[mem_addr] <= mem_wdata;
            if (mem_en && mem_r_en) mem_rdata <= mem[mem_addr];
        end
    end
endmodule

// File: tb/tb_decode_exec_mem.sv
// Directed test for decode_exec_mem: decode flags, ALU ops, branches, memory and reset.
module tb_decode_exec_mem;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instruction, pc, in0, in1, mem_addr, mem_wdata;
    logic       exec_en, mem_en;
    logic [1:0] reg_addr_0, reg_addr_1, reg_addr_w;
    logic       reg_w_en, mem_w_en, mem_r_en, sel_w_source, jump, halt;
    logic [7:0] alu_result, mem_rdata;
    logic       overflow, branch;

    int n_checks = 0;
    int n_fail   = 0;

    decode_exec_mem #(.DATA_W(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .pc(pc),
        .in0(in0), .in1(in1), .exec_en(exec_en), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1), .reg_addr_w(reg_addr_w),
        .reg_w_en(reg_w_en), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .sel_w_source(sel_w_source), .jump(jump), .halt(halt),
        .alu_result(alu_result), .overflow(overflow), .branch(branch),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exec(input logic [7:0] ins, input logic [7:0] a, input logic [7:0] b);
        instruction = ins; in0 = a; in1 = b;
        exec_en = 1'b1;
        step();
        exec_en = 1'b0;
    endtask

    task automatic mem_op(input logic [7:0] ins, input logic [7:0] addr, input logic [7:0] wd);
        instruction = ins; mem_addr = addr; mem_wdata = wd;
        mem_en = 1'b1;
        step();
        mem_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instruction = 8'h00; pc = 8'h00; in0 = 8'h00; in1 = 8'h00;
        exec_en = 1'b0; mem_en = 1'b0; mem_addr = 8'h00; mem_wdata = 8'h00;
        step(); step();
        chk("reset_alu", alu_result, 8'h00);
        chk("reset_ovf", {7'b0, overflow}, 8'h00);
        chk("reset_branch", {7'b0, branch}, 8'h00);
        chk("reset_rdata", mem_rdata, 8'h00);
        chk("halt_in_reset", {7'b0, halt}, 8'h01);
        reset = 1'b0;

        exec(8'h14, 8'h7F, 8'h01);
        chk("add_result", alu_result, 8'h80);
        chk("add_ovf", {7'b0, overflow}, 8'h01);
        chk("add_reg_w_en", {7'b0, reg_w_en}, 8'h01);
        chk("add_reg_addr_w", {6'b0, reg_addr_w}, 8'h01);
        chk("add_reg_addr_0", {6'b0, reg_addr_0}, 8'h01);
        chk("add_reg_addr_1", {6'b0, reg_addr_1}, 8'h00);

        instruction = 8'h24; in0 = 8'h80; in1 = 8'h01;
        step();
        chk("hold_alu", alu_result, 8'h80);
        chk("hold_ovf", {7'b0, overflow}, 8'h01);

        exec(8'h24, 8'h80, 8'h01);
        chk("sub_result", alu_result, 8'h7F);
        chk("sub_ovf", {7'b0, overflow}, 8'h01);
        exec(8'h97, 8'h7E, 8'h00);
        chk("addi_result", alu_result, 8'h81);
        chk("addi_ovf", {7'b0, overflow}, 8'h01);
        exec(8'h50, 8'hF0, 8'h3C);
        chk("xor_result", alu_result, 8'hCC);
        chk("xor_ovf", {7'b0, overflow}, 8'h00);
        exec(8'h30, 8'hF0, 8'h3C);
        chk("and_result", alu_result, 8'h30);
        exec(8'h40, 8'hF0, 8'h3C);
        chk("or_result", alu_result, 8'hFC);
        exec(8'h80, 8'h00, 8'h81);
        chk("shr_result", alu_result, 8'h40);
        exec(8'h70, 8'h00, 8'h81);
        chk("shl_result", alu_result, 8'h02);
        exec(8'h60, 8'h00, 8'h0F);
        chk("not_result", alu_result, 8'hF0);
        exec(8'hE0, 8'h12, 8'h34);
        chk("j_result", alu_result, 8'h00);
        chk("j_branch", {7'b0, branch}, 8'h01);

        instruction = 8'hB0;
        #1;
        chk("sw_mem_w_en", {7'b0, mem_w_en}, 8'h01);
        mem_op(8'hB0, 8'h10, 8'hA5);
        chk("sw_rdata_hold", mem_rdata, 8'h00);
        instruction = 8'hA0;
        #1;
        chk("lw_sel_w_source", {7'b0, sel_w_source}, 8'h01);
        chk("lw_mem_r_en", {7'b0, mem_r_en}, 8'h01);
        mem_op(8'hA0, 8'h10, 8'h00);
        chk("lw_rdata", mem_rdata, 8'hA5);
        mem_op(8'h00, 8'h10, 8'h77);
        chk("nop_mem_rdata_hold", mem_rdata, 8'hA5);
        mem_op(8'hA0, 8'h10, 8'h00);
        chk("nop_mem_unchanged", mem_rdata, 8'hA5);

        exec(8'hC1, 8'h33, 8'h33);
        chk("beq_branch", {7'b0, branch}, 8'h01);
        chk("beq_result", alu_result, 8'h00);
        chk("beq_reg_w_en", {7'b0, reg_w_en}, 8'h00);
        exec(8'hD1, 8'h33, 8'h33);
        chk("bne_branch", {7'b0, branch}, 8'h00);
        chk("bne_jump", {7'b0, jump}, 8'h01);
        exec(8'hD1, 8'h35, 8'h33);
        chk("bne_taken", {7'b0, branch}, 8'h01);
        chk("bne_result", alu_result, 8'h02);

        pc = 8'hFF;
        exec(8'hF4, 8'h00, 8'h00);
        chk("jal_result", alu_result, 8'h00);
        chk("jal_reg_addr_w", {6'b0, reg_addr_w}, 8'h03);
        chk("jal_branch", {7'b0, branch}, 8'h01);
        chk("jal_reg_w_en", {7'b0, reg_w_en}, 8'h01);

        mem_op(8'hB0, 8'h03, 8'h5A);
        instruction = 8'hA0; mem_addr = 8'h03; in0 = 8'h00; in1 = 8'h00;
        exec_en = 1'b1; mem_en = 1'b1;
        step();
        exec_en = 1'b0; mem_en = 1'b0;
        chk("dual_rdata", mem_rdata, 8'h5A);
        chk("dual_lw_alu", alu_result, 8'h00);

        exec(8'h14, 8'h02, 8'h03);
        chk("pre_reset_alu", alu_result, 8'h05);
        reset = 1'b1; instruction = 8'h14; exec_en = 1'b1; mem_en = 1'b1;
        step();
        reset = 1'b0; exec_en = 1'b0; mem_en = 1'b0;
        chk("reset_prio_alu", alu_result, 8'h00);
        chk("reset_prio_rdata", mem_rdata, 8'h00);
        mem_op(8'hA0, 8'h03, 8'h00);
        chk("reset_clears_mem", mem_rdata, 8'h00);
        mem_op(8'hA0, 8'h10, 8'h00);
        chk("reset_clears_mem2", mem_rdata, 8'h00);
        instruction = 8'h00;
        #1;
        chk("halt_00", {7'b0, halt}, 8'h01);
        instruction = 8'h01;
        #1;
        chk("halt_01", {7'b0, halt}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_exec_mem.md
DECODE_EXEC_MEM -- requirements
Module: decode_exec_mem

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-high.
REQ-002 The module SHALL use these parameters (name, default, meaning): DATA_W, 8, datapath width; MEM_DEPTH, 256, data-memory bytes addressed by 8 bits.
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- instruction  in  8  [7:4] opcode, [3:2] field A, [1:0] field B
- pc  in  8  current program counter
- in0  in  8  register data of field A
- in1  in  8  register data of field B
- exec_en  in  1  one-cycle execute strobe
- mem_en  in  1  one-cycle memory-access strobe
- mem_addr  in  8  data-memory address
- mem_wdata  in  8  data-memory write data
- reg_addr_0 / reg_addr_1 / reg_addr_w  out  2 each  source A, source B, destination
- reg_w_en, mem_w_en, mem_r_en, sel_w_source, jump, halt  out  1 each  decode flags
- alu_result  out  8  registered ALU result
- overflow  out  1  registered signed overflow
- branch  out  1  registered branch-taken flag
- mem_rdata  out  8  registered memory read data

Function
REQ-004 Decode outputs SHALL be combinational from instruction: reg_addr_0=[3:2], reg_addr_1=[1:0], reg_addr_w=[3:2], except JAL where reg_addr_w=3.
REQ-005 Opcodes SHALL be: 0000 NOP; 0001 ADD A=A+B; 0010 SUB A=A-B; 0011 AND; 0100 OR; 0101 XOR; 0110 NOT A=~B; 0111 SHL A=B<<1; 1000 SHR A=B>>1 (logical); 1001 ADDI A=A+zext(B field); 1010 LW A=mem; 1011 SW mem=B; 1100 BEQ; 1101 BNE; 1110 J; 1111 JAL r3=pc+1.
REQ-006 reg_w_en SHALL be 1 for opcodes 0001-1010 and 1111, else 0.
REQ-007 mem_r_en and sel_w_source SHALL be 1 only for LW; mem_w_en SHALL be 1 only for SW.
REQ-008 jump SHALL be 1 for opcodes 1100-1111; halt SHALL be 1 only when instruction==8'h00.
REQ-009 On a clk edge with exec_en=1, alu_result, overflow and branch SHALL update; with exec_en=0 they SHALL hold.
REQ-010 Arithmetic SHALL be modulo 256; overflow SHALL be 1 only for ADD/ADDI/SUB when the signed 8-bit result overflows, else 0.
REQ-011 For BEQ/BNE, alu_result SHALL be in0-in1, and branch SHALL be (in0==in1) for BEQ or (in0!=in1) for BNE; branch SHALL be 1 for J/JAL and 0 for all other opcodes.
REQ-012 For JAL, alu_result SHALL be pc+1 (wrap 8'hFF to 8'h00).
REQ-013 For NOP, LW, SW and J, alu_result SHALL be 0.
REQ-014 For opcode 1001, the immediate SHALL be instruction[1:0], zero-extended.
REQ-015 Data memory SHALL be 256x8. On a clk edge with mem_en=1 and mem_w_en=1, mem[mem_addr] SHALL be set to mem_wdata, and mem_rdata SHALL hold.
REQ-016 On a clk edge with mem_en=1 and mem_r_en=1, mem_rdata SHALL be set to mem[mem_addr] (one-cycle read latency).
REQ-017 If mem_en=1 but neither mem_r_en nor mem_w_en is set, memory and mem_rdata SHALL be unchanged.
REQ-018 If exec_en and mem_en are asserted in the same cycle, both SHALL act independently.
REQ-019 The memory read SHALL return the pre-edge contents.

Reset
REQ-020 When reset=1 at a clk edge, alu_result, overflow, branch and mem_rdata SHALL be set to 0 and all memory bytes SHALL be cleared to 0; reset SHALL take priority over exec_en and mem_en.
REQ-021 Decode outputs SHALL be unaffected by reset.
REQ-022 When reset is asserted mid-operation, pending strobes in that cycle SHALL be discarded.

Verification
REQ-023 ADD overflow: instruction=8'h14, in0=8'h7F, in1=8'h01, exec_en pulse -> alu_result=8'h80, overflow=1, reg_w_en=1, reg_addr_w=1.
REQ-024 Store then load: SW with mem_addr=8'h10, mem_wdata=8'hA5 and mem_en pulse; then LW (8'hA0) with mem_addr=8'h10 and mem_en pulse -> mem_rdata=8'hA5 one cycle later, sel_w_source=1.
REQ-025 Branches: BEQ (8'hC1) with in0=in1=8'h33 -> branch=1; BNE (8'hD1) with the same inputs -> branch=0, jump=1.
REQ-026 JAL wrap: instruction=8'hF4, pc=8'hFF, exec_en pulse -> alu_result=8'h00, reg_addr_w=3, branch=1.
REQ-027 Reset clears memory: write 8'h5A to address 3, assert reset one cycle, then read address 3 -> mem_rdata=8'h00; halt=1 for instruction=8'h00.
